// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the iterative multiply/divide unit
package muldiv_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } iterMode_t;

  function automatic logic isMulDiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // MULT and DIV are the even encodings of the multi-cycle group
  function automatic logic isSignedOp(input logic [2:0] op);
    return (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - radix-2 shift-add multiply / restoring divide datapath
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Load,
  input  iterMode_t         LoadMode,
  input  logic              Step,
  input  logic [DATA_W-1:0] OpA,
  input  logic [DATA_W-1:0] OpB,
  output logic [DATA_W-1:0] ResHi,
  output logic [DATA_W-1:0] ResLo
);

  iterMode_t         modeQ;
  logic [DATA_W:0]   partHi;
  logic [DATA_W-1:0] partLo;
  logic [DATA_W-1:0] operand;

  logic [DATA_W:0]   addSum;
  logic [DATA_W+1:0] shifted;
  logic [DATA_W+1:0] trial;

  // partHi never exceeds DATA_W significant bits, so the adds cannot overflow
  always_comb begin
    addSum  = partHi + (partLo[0] ? {1'b0, operand} : '0);
    shifted = {partHi, partLo[DATA_W-1]};
    trial   = shifted - {2'b00, operand};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      modeQ   <= MODE_MUL;
      partHi  <= '0;
      partLo  <= '0;
      operand <= '0;
    end else if (Load) begin
      modeQ  <= LoadMode;
      partHi <= '0;
      if (LoadMode == MODE_MUL) begin
        partLo  <= OpB;
        operand <= OpA;
      end else begin
        partLo  <= OpA;
        operand <= OpB;
      end
    end else if (Step) begin
      if (modeQ == MODE_MUL) begin
        partHi <= {1'b0, addSum[DATA_W:1]};
        partLo <= {addSum[0], partLo[DATA_W-1:1]};
      end else if (trial[DATA_W+1]) begin
        partHi <= shifted[DATA_W:0];
        partLo <= {partLo[DATA_W-2:0], 1'b0};
      end else begin
        partHi <= trial[DATA_W:0];
        partLo <= {partLo[DATA_W-2:0], 1'b1};
      end
    end
  end

  assign ResHi = partHi[DATA_W-1:0];
  assign ResLo = partLo;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - MIPS HI/LO multiply/divide unit: FSM, sign handling, HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [2:0]        Op,
  input  logic [DATA_W-1:0] Rs,
  input  logic [DATA_W-1:0] Rt,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo,
  output logic              Busy,
  output logic              Done
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              finPhase;
  logic              isDiv;
  logic              negA;
  logic              negB;
  logic              divZero;
  logic [DATA_W-1:0] rsRaw;
  logic [DATA_W-1:0] resHi;
  logic [DATA_W-1:0] resLo;

  logic              accept;
  logic              opSigned;
  logic [DATA_W-1:0] magA;
  logic [DATA_W-1:0] magB;
  logic [DATA_W-1:0] iterHi;
  logic [DATA_W-1:0] iterLo;

  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   fixHi;
  logic [DATA_W-1:0]   fixLo;

  always_comb begin
    accept   = (state == ST_IDLE) && Start && isMulDiv(Op);
    opSigned = isSignedOp(Op);
    magA     = (opSigned && Rs[DATA_W-1]) ? -Rs : Rs;
    magB     = (opSigned && Rt[DATA_W-1]) ? -Rt : Rt;
  end

  muldiv_iter #(.DATA_W(DATA_W)) uIter (
    .Clk      (Clk),
    .Rst      (Rst),
    .Load     (accept),
    .LoadMode (Op[1] ? MODE_DIV : MODE_MUL),
    .Step     (state == ST_RUN),
    .OpA      (magA),
    .OpB      (magB),
    .ResHi    (iterHi),
    .ResLo    (iterLo)
  );

  // Sign fix-up is registered in the first FIN cycle so the negators stay off the Hi/Lo path
  always_comb begin
    product = {iterHi, iterLo};
    quo     = (negA ^ negB) ? -iterLo : iterLo;
    rem     = negA ? -iterHi : iterHi;
    fixHi   = '0;
    fixLo   = '0;
    if (!isDiv) begin
      if (negA ^ negB) begin
        {fixHi, fixLo} = -product;
      end else begin
        {fixHi, fixLo} = product;
      end
    end else if (divZero) begin
      fixHi = rsRaw;
      fixLo = '1;
    end else begin
      fixHi = rem;
      fixLo = quo;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      finPhase <= 1'b0;
      isDiv    <= 1'b0;
      negA     <= 1'b0;
      negB     <= 1'b0;
      divZero  <= 1'b0;
      rsRaw    <= '0;
      resHi    <= '0;
      resLo    <= '0;
      Hi       <= '0;
      Lo       <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            isDiv   <= Op[1];
            negA    <= opSigned && Rs[DATA_W-1];
            negB    <= opSigned && Rt[DATA_W-1];
            divZero <= (Rt == '0);
            rsRaw   <= Rs;
            cnt     <= '0;
            state   <= ST_RUN;
          end else if (Start && Op == OP_MTHI) begin
            Hi <= Rs;
          end else if (Start && Op == OP_MTLO) begin
            Lo <= Rs;
          end
        end
        ST_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W - 1)) begin
            finPhase <= 1'b0;
            state    <= ST_FIN;
          end
        end
        ST_FIN: begin
          if (!finPhase) begin
            resHi    <= fixHi;
            resLo    <= fixLo;
            finPhase <= 1'b1;
          end else begin
            Hi    <= resHi;
            Lo    <= resLo;
            Done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] Rs;
  logic [31:0] Rt;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[9];

  always #5 Clk = ~Clk;

  muldiv_unit dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .Op    (Op),
    .Rs    (Rs),
    .Rt    (Rt),
    .Hi    (Hi),
    .Lo    (Lo),
    .Busy  (Busy),
    .Done  (Done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Architectural reference: plain 64-bit arithmetic, C-style truncating division
  task automatic model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint a, b, p, q, r;
    logic [63:0] u;
    hi = '0;
    lo = '0;
    case (op)
      OP_MULT: begin
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        p = a * b;
        {hi, lo} = p;
      end
      OP_MULTU: begin
        u = {32'd0, rs} * {32'd0, rt};
        {hi, lo} = u;
      end
      OP_DIV: begin
        if (rt == 0) begin
          hi = rs;
          lo = 32'hFFFF_FFFF;
        end else begin
          a = longint'($signed(rs));
          b = longint'($signed(rt));
          q = a / b;
          r = a % b;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      default: begin
        if (rt == 0) begin
          hi = rs;
          lo = 32'hFFFF_FFFF;
        end else begin
          lo = rs / rt;
          hi = rs % rt;
        end
      end
    endcase
  endtask

  // Issues one op; returns as soon as Done is seen so the next call is back-to-back
  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] expHi, input logic [31:0] expLo);
    logic [31:0] prevHi, prevLo;
    int lat, busyBad, holdBad;
    prevHi = Hi;
    prevLo = Lo;
    Start = 1'b1;
    Op = op;
    Rs = rs;
    Rt = rt;
    tick;
    Start = 1'b0;
    Op = 3'($urandom);
    Rs = $urandom;
    Rt = $urandom;
    lat = 0;
    busyBad = 0;
    holdBad = 0;
    while (!Done && lat < 40) begin
      if (!Busy) busyBad++;
      if (Hi !== prevHi || Lo !== prevLo) holdBad++;
      tick;
      lat++;
    end
    check({name, " latency"}, lat, 34);
    check({name, " busy during run"}, busyBad, 0);
    check({name, " hi/lo hold"}, holdBad, 0);
    check({name, " busy at done"}, {31'd0, Busy}, 0);
    check({name, " hi"}, Hi, expHi);
    check({name, " lo"}, Lo, expLo);
  endtask

  initial begin
    logic [31:0] h, l, rs, rt, keepHi, keepLo;
    logic [2:0]  op;
    int n, doneSeen;

    vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{OP_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[7] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    Rst = 1'b1;
    Start = 1'b0;
    Op = '0;
    Rs = '0;
    Rt = '0;
    tick;
    tick;
    Rst = 1'b0;
    check("reset hi", Hi, 0);
    check("reset lo", Lo, 0);
    check("reset busy", {31'd0, Busy}, 0);
    check("reset done", {31'd0, Done}, 0);

    Start = 1'b1;
    Op = OP_MTHI;
    Rs = 32'h1234_5678;
    tick;
    Start = 1'b0;
    check("mthi hi", Hi, 32'h1234_5678);
    check("mthi lo untouched", Lo, 0);
    check("mthi busy", {31'd0, Busy}, 0);
    check("mthi done", {31'd0, Done}, 0);

    Start = 1'b1;
    Op = OP_MTLO;
    Rs = 32'hCAFE_F00D;
    tick;
    Start = 1'b0;
    check("mtlo lo", Lo, 32'hCAFE_F00D);
    check("mtlo hi untouched", Hi, 32'h1234_5678);

    Start = 1'b1;
    Op = 3'b110;
    Rs = 32'hDEAD_BEEF;
    tick;
    Start = 1'b0;
    tick;
    check("noop hi", Hi, 32'h1234_5678);
    check("noop lo", Lo, 32'hCAFE_F00D);
    check("noop busy", {31'd0, Busy}, 0);

    for (int i = 0; i < 9; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo);
    end
    tick;
    check("done one cycle", {31'd0, Done}, 0);

    // MTLO/MTHI arriving mid-operation must be dropped
    Start = 1'b1;
    Op = OP_MULT;
    Rs = 32'd6;
    Rt = 32'hFFFF_FFFE;
    tick;
    Start = 1'b0;
    repeat (5) tick;
    Start = 1'b1;
    Op = OP_MTLO;
    Rs = 32'h0000_0055;
    tick;
    Op = OP_MTHI;
    tick;
    Start = 1'b0;
    n = 0;
    while (!Done && n < 40) begin
      tick;
      n++;
    end
    check("busy mtlo done seen", {31'd0, Done}, 1);
    check("busy mtlo lo", Lo, 32'hFFFF_FFF4);
    check("busy mtlo hi", Hi, 32'hFFFF_FFFF);
    tick;

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: rs = 32'h8000_0000;
        1: rs = 32'hFFFF_FFFF;
        default: rs = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rt = 32'd0;
        1: rt = 32'hFFFF_FFFF;
        2: rt = 32'($urandom_range(1, 15));
        default: rt = $urandom;
      endcase
      model(op, rs, rt, h, l);
      runOp($sformatf("rand%0d op%0d %h %h", i, op, rs, rt), op, rs, rt, h, l);
    end

    // Reset mid-operation aborts without Done
    keepHi = Hi;
    keepLo = Lo;
    Start = 1'b1;
    Op = OP_MULTU;
    Rs = 32'd3;
    Rt = 32'd4;
    tick;
    Start = 1'b0;
    check("abort prior done low", {31'd0, Done}, 0);
    check("abort busy before rst", {31'd0, Busy}, 1);
    repeat (9) tick;
    Rst = 1'b1;
    tick;
    Rst = 1'b0;
    check("abort hi", Hi, 0);
    check("abort lo", Lo, 0);
    check("abort busy", {31'd0, Busy}, 0);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) doneSeen++;
      tick;
    end
    check("abort no done", doneSeen, 0);
    check("abort prior hi nonzero", {31'd0, (keepHi != 0 || keepLo != 0)}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
